// File: rtl/seg_display_ctrl.sv
// Registered multi-digit 7-segment controller: latches a display frame on load and
// drives N_DIG common-cathode digit buses with hex decode, DP, blank, blink and LZB.
module seg_display_ctrl #(
    parameter int N_DIG     = 2,
    parameter int BLINK_DIV = 6000000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [4*N_DIG-1:0]   data_in,
    input  logic [N_DIG-1:0]     dp_in,
    input  logic [N_DIG-1:0]     blank_mask,
    input  logic [N_DIG-1:0]     blink_mask,
    input  logic                 hex_en,
    input  logic                 lzb_en,
    output logic                 load_ack,
    output logic [9*N_DIG-1:0]   segment_led
);

    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    logic [4*N_DIG-1:0] data_p0;
    logic [N_DIG-1:0]   dp_p0;
    logic [N_DIG-1:0]   blank_p0;
    logic [N_DIG-1:0]   blink_p0;
    logic               hex_p0;
    logic               lzb_p0;
    logic               vld_p0;

    logic [CNT_W-1:0]   blink_cnt;
    logic               blink_phase;

    logic [9*N_DIG-1:0] seg_p1;
    logic               vld_p1;

    logic [N_DIG-1:0]   lz_sup;
    logic               zero_run;
    logic [9*N_DIG-1:0] seg_next;

    function automatic logic [6:0] decode_seg(input logic [3:0] val, input logic hex);
        logic [6:0] seg;
        case (val)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = hex ? 7'h77 : 7'h40;
            4'hB: seg = hex ? 7'h7C : 7'h40;
            4'hC: seg = hex ? 7'h39 : 7'h40;
            4'hD: seg = hex ? 7'h5E : 7'h40;
            4'hE: seg = hex ? 7'h79 : 7'h40;
            default: seg = hex ? 7'h71 : 7'h40;
        endcase
        return seg;
    endfunction

    // A digit stays suppressed while it and every more-significant digit are a bare zero.
    always_comb begin
        lz_sup   = '0;
        zero_run = lzb_p0;
        for (int i = N_DIG - 1; i >= 0; i--) begin
            zero_run  = zero_run && (data_p0[4*i +: 4] == 4'd0) && !dp_p0[i];
            lz_sup[i] = zero_run && (i != 0);
        end
    end

    always_comb begin
        seg_next = '0;
        for (int i = 0; i < N_DIG; i++) begin
            if (blank_p0[i] || (blink_p0[i] && blink_phase) || lz_sup[i])
                seg_next[9*i +: 9] = 9'h100;
            else
                seg_next[9*i +: 9] = {1'b0, dp_p0[i], decode_seg(data_p0[4*i +: 4], hex_p0)};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_p0     <= '0;
            dp_p0       <= '0;
            blank_p0    <= '0;
            blink_p0    <= '0;
            hex_p0      <= 1'b0;
            lzb_p0      <= 1'b0;
            vld_p0      <= 1'b0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            seg_p1      <= {N_DIG{9'h100}};
            vld_p1      <= 1'b0;
        end else begin
            // p0: frame shadow
            if (load) begin
                data_p0  <= data_in;
                dp_p0    <= dp_in;
                blank_p0 <= blank_mask;
                blink_p0 <= blink_mask;
                hex_p0   <= hex_en;
                lzb_p0   <= lzb_en;
            end
            vld_p0 <= load;

            if (blink_cnt == CNT_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + CNT_W'(1);
            end

            // p1: registered digit buses
            seg_p1 <= seg_next;
            vld_p1 <= vld_p0;
        end
    end

    assign segment_led = seg_p1;
    assign load_ack    = vld_p1;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: behavioural frame model compared every
// cycle, plus literal expectations for reset, decode, LZB, blink and back-to-back loads.
module tb_seg_display_ctrl;

    localparam int N_DIG     = 4;
    localparam int BLINK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] data_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  blank_mask = '0;
    logic [3:0]  blink_mask = '0;
    logic        hex_en = 1'b0;
    logic        lzb_en = 1'b0;
    logic        load_ack;
    logic [35:0] segment_led;

    int checks = 0;
    int errors = 0;
    logic chk_en = 1'b0;

    seg_display_ctrl #(.N_DIG(N_DIG), .BLINK_DIV(BLINK_DIV)) dut (
        .clk(clk), .rst_n(rst_n), .load(load), .data_in(data_in), .dp_in(dp_in),
        .blank_mask(blank_mask), .blink_mask(blink_mask), .hex_en(hex_en),
        .lzb_en(lzb_en), .load_ack(load_ack), .segment_led(segment_led)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: what the display should hold, and how many edges since reset release.
    logic [15:0] m_data = '0;
    logic [3:0]  m_dp = '0, m_blank = '0, m_blink = '0;
    logic        m_hex = 1'b0, m_lzb = 1'b0, m_ldq = 1'b0;
    int          m_edges = 0;
    logic [35:0] exp_seg = {4{9'h100}};
    logic        exp_ack = 1'b0;

    function automatic logic [35:0] model_frame(input logic [15:0] d, input logic [3:0] dp,
                                                input logic [3:0] bl, input logic [3:0] bk,
                                                input logic hx, input logic lz, input logic ph);
        logic [35:0] r;
        logic [3:0]  v;
        logic [6:0]  s;
        logic        sup;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            v = d[4*i +: 4];
            s = (v < 4'd10 || hx) ? seg_tbl[v] : 7'h40;
            sup = lz && (i > 0);
            for (int j = i; j < 4; j++)
                if (d[4*j +: 4] != 4'd0 || dp[j]) sup = 1'b0;
            if (bl[i] || (bk[i] && ph) || sup) r[9*i +: 9] = 9'h100;
            else                               r[9*i +: 9] = {1'b0, dp[i], s};
        end
        return r;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_data <= '0; m_dp <= '0; m_blank <= '0; m_blink <= '0;
            m_hex <= 1'b0; m_lzb <= 1'b0; m_ldq <= 1'b0; m_edges <= 0;
            exp_seg <= {4{9'h100}};
            exp_ack <= 1'b0;
        end else begin
            exp_seg <= model_frame(m_data, m_dp, m_blank, m_blink, m_hex, m_lzb,
                                   ((m_edges / BLINK_DIV) % 2) == 1);
            exp_ack <= m_ldq;
            m_ldq   <= load;
            if (load) begin
                m_data <= data_in; m_dp <= dp_in; m_blank <= blank_mask;
                m_blink <= blink_mask; m_hex <= hex_en; m_lzb <= lzb_en;
            end
            m_edges <= m_edges + 1;
        end
    end

    task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_seg", segment_led, exp_seg);
            check("model_ack", {35'd0, load_ack}, {35'd0, exp_ack});
        end
    end

    task automatic drive_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl,
                              input logic [3:0] bk, input logic hx, input logic lz);
        @(negedge clk);
        data_in = d; dp_in = dp; blank_mask = bl; blink_mask = bk; hex_en = hx; lzb_en = lz;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        data_in = 16'($urandom); dp_in = 4'($urandom); hex_en = 1'($urandom); lzb_en = 1'($urandom);
    endtask

    task automatic load_frame(input string name, input logic [15:0] d, input logic [3:0] dp,
                              input logic hx, input logic lz, input logic [35:0] exp);
        drive_load(d, dp, 4'b0000, 4'b0000, hx, lz);
        @(posedge clk); #1;
        check({name, "_seg"}, segment_led, exp);
        check({name, "_ack"}, {35'd0, load_ack}, 36'd1);
        @(posedge clk); #1;
        check({name, "_hold"}, segment_led, exp);
        check({name, "_ack_low"}, {35'd0, load_ack}, 36'd0);
    endtask

    logic [35:0] samp [16];
    int chg;

    initial begin
        repeat (3) @(negedge clk);
        check("reset_seg", segment_led, {4{9'h100}});
        check("reset_ack", {35'd0, load_ack}, 36'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        check("release_zero", segment_led, {4{9'h03F}});

        // asynchronous reset mid-cycle
        @(negedge clk); #2 rst_n = 1'b0; #1;
        check("async_reset_seg", segment_led, {4{9'h100}});
        check("async_reset_ack", {35'd0, load_ack}, 36'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("rerelease_zero", segment_led, {4{9'h03F}});

        load_frame("dec1234", 16'h1234, 4'b0100, 1'b0, 1'b0, {9'h006, 9'h0DB, 9'h04F, 9'h066});
        load_frame("hexABCF", 16'hABCF, 4'b0000, 1'b1, 1'b0, {9'h077, 9'h07C, 9'h039, 9'h071});
        load_frame("dashABCF", 16'hABCF, 4'b0000, 1'b0, 1'b0, {4{9'h040}});
        load_frame("lzb0007", 16'h0007, 4'b0000, 1'b0, 1'b1, {9'h100, 9'h100, 9'h100, 9'h007});
        load_frame("lzb0000", 16'h0000, 4'b0000, 1'b0, 1'b1, {9'h100, 9'h100, 9'h100, 9'h03F});
        load_frame("lzb0005dp", 16'h0005, 4'b0100, 1'b0, 1'b1, {9'h100, 9'h0BF, 9'h03F, 9'h06D});

        // blink and blank, with a reload in the middle of the sampling window
        drive_load(16'h8888, 4'b0000, 4'b1000, 4'b0001, 1'b0, 1'b0);
        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            samp[i] = segment_led;
            if (i == 5) begin
                data_in = 16'h8888; dp_in = '0; blank_mask = 4'b1000; blink_mask = 4'b0001;
                hex_en = 1'b0; lzb_en = 1'b0; load = 1'b1;
            end
            if (i == 6) load = 1'b0;
        end
        chg = 0;
        for (int i = 0; i < 16; i++) begin
            check("blink_upper", samp[i][35:9], {9'h100, 9'h07F, 9'h07F});
            check("blink_d0_legal", {35'd0, (samp[i][8:0] == 9'h07F) || (samp[i][8:0] == 9'h100)}, 36'd1);
            if (i < 12) check("blink_alt4", {35'd0, samp[i][8:0] != samp[i+4][8:0]}, 36'd1);
            if (i < 15 && samp[i][8:0] != samp[i+1][8:0]) chg++;
        end
        check("blink_runs", {35'd0, (chg == 3) || (chg == 4)}, 36'd1);

        // back-to-back loads
        blank_mask = '0; blink_mask = '0; dp_in = '0; hex_en = 1'b0; lzb_en = 1'b0;
        @(negedge clk); load = 1'b1; data_in = 16'h0001;
        @(negedge clk); data_in = 16'h0002;
        @(negedge clk);
        check("b2b_v1", segment_led, {9'h03F, 9'h03F, 9'h03F, 9'h006});
        check("b2b_ack1", {35'd0, load_ack}, 36'd1);
        data_in = 16'h0003;
        @(negedge clk);
        check("b2b_v2", segment_led, {9'h03F, 9'h03F, 9'h03F, 9'h05B});
        check("b2b_ack2", {35'd0, load_ack}, 36'd1);
        load = 1'b0;
        @(negedge clk);
        check("b2b_v3", segment_led, {9'h03F, 9'h03F, 9'h03F, 9'h04F});
        check("b2b_ack3", {35'd0, load_ack}, 36'd1);
        @(negedge clk);
        check("b2b_ack_end", {35'd0, load_ack}, 36'd0);

        // reset in the middle of a frame load
        load = 1'b1; data_in = 16'h9999;
        #2 rst_n = 1'b0; #1;
        check("midframe_rst_seg", segment_led, {4{9'h100}});
        check("midframe_rst_ack", {35'd0, load_ack}, 36'd0);
        @(negedge clk); rst_n = 1'b1; load = 1'b0;
        @(posedge clk); #1;
        check("midframe_after_seg", segment_led, {4{9'h03F}});
        check("midframe_after_ack", {35'd0, load_ack}, 36'd0);

        // randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            load       = ($urandom_range(0, 2) == 0);
            data_in    = 16'($urandom);
            if ($urandom_range(0, 3) == 0) data_in = data_in & 16'h00F0;
            dp_in      = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            blank_mask = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0000;
            blink_mask = 4'($urandom);
            hex_en     = 1'($urandom);
            lzb_en     = 1'($urandom);
            if ($urandom_range(0, 99) == 0) begin
                #2 rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
